// File: rtl/order_book_pkg.sv
// rtl/order_book_pkg.sv - shared order-book field layout, marker words and encodings
package order_book_pkg;

    localparam int DEF_ID_W    = 16;
    localparam int DEF_PRICE_W = 16;
    localparam int DEF_QTY_W   = 16;
    localparam int DEF_W       = DEF_ID_W + DEF_PRICE_W + DEF_QTY_W;

    // Order word is {id, price, qty}, MSB first.
    localparam int QTY_LSB   = 0;
    localparam int PRICE_LSB = DEF_QTY_W;
    localparam int ID_LSB    = DEF_QTY_W + DEF_PRICE_W;

    localparam logic [DEF_W-1:0] EMPTY_WORD     = '0;
    localparam logic [DEF_W-1:0] TOMBSTONE_WORD = '1;

    localparam logic [1:0] SIDE_SEL_NONE = 2'b00;
    localparam logic [1:0] SIDE_SEL_BUY  = 2'b01;
    localparam logic [1:0] SIDE_SEL_SELL = 2'b10;
    localparam logic [1:0] SIDE_SEL_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_DELETED   = 2'b00,
        ST_REDUCED   = 2'b01,
        ST_NOT_FOUND = 2'b10,
        ST_BAD_REQ   = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_e;

endpackage

// File: rtl/order_cancel_engine.sv
// rtl/order_cancel_engine.sv - linear-scan cancel/reduce of one order in external buy/sell book RAMs
module order_cancel_engine
    import order_book_pkg::*;
#(
    parameter int ID_W    = DEF_ID_W,
    parameter int PRICE_W = DEF_PRICE_W,
    parameter int QTY_W   = DEF_QTY_W,
    parameter int DEPTH   = 4096,
    localparam int W      = ID_W + PRICE_W + QTY_W,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ID_W-1:0]   id,
    input  logic [1:0]        side_sel,
    input  logic [QTY_W-1:0]  reduce_qty,
    output logic [ADDR_W-1:0] buy_addr,
    input  logic [W-1:0]      buy_rdata,
    output logic [W-1:0]      buy_wdata,
    output logic              buy_we,
    output logic [ADDR_W-1:0] sell_addr,
    input  logic [W-1:0]      sell_rdata,
    output logic [W-1:0]      sell_wdata,
    output logic              sell_we,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic              hit_side,
    output logic [ADDR_W-1:0] hit_addr,
    output logic [QTY_W-1:0]  old_qty
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [W-1:0]      EMPTY    = '0;
    localparam logic [W-1:0]      TOMB     = '1;
    localparam logic [ID_W-1:0]   ID_ONES  = '1;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [1:0]          side_sel_q, side_sel_d;
    logic [QTY_W-1:0]    reduce_q, reduce_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic                side_q, side_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                buy_we_q, buy_we_d;
    logic                sell_we_q, sell_we_d;
    logic [W-1:0]        wdata_q, wdata_d;
    status_e             status_q, status_d;
    logic                hit_side_q, hit_side_d;
    logic [ADDR_W-1:0]   hit_addr_q, hit_addr_d;
    logic [QTY_W-1:0]    old_qty_q, old_qty_d;

    logic [W-1:0]        word;
    logic [ID_W-1:0]     word_id;
    logic [W-QTY_W-1:0]  word_head;
    logic [QTY_W-1:0]    word_qty;

    assign word      = side_q ? sell_rdata : buy_rdata;
    assign word_id   = word[W-1 -: ID_W];
    assign word_head = word[W-1:QTY_W];
    assign word_qty  = word[QTY_W-1:0];

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        side_sel_d = side_sel_q;
        reduce_d   = reduce_q;
        index_d    = index_q;
        side_d     = side_q;
        buy_we_d   = 1'b0;
        sell_we_d  = 1'b0;
        wdata_d    = wdata_q;
        status_d   = status_q;
        hit_side_d = hit_side_q;
        hit_addr_d = hit_addr_q;
        old_qty_d  = old_qty_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hit_side_d = 1'b0;
                    hit_addr_d = '0;
                    old_qty_d  = '0;
                    if (id == '0 || id == ID_ONES || side_sel == SIDE_SEL_NONE) begin
                        status_d = ST_BAD_REQ;
                        state_d  = S_DONE;
                    end else begin
                        id_d       = id;
                        side_sel_d = side_sel;
                        reduce_d   = reduce_qty;
                        index_d    = '0;
                        side_d     = ~side_sel[0];
                        state_d    = S_SCAN;
                    end
                end
            end
            S_SCAN: state_d = S_CHECK;
            S_CHECK: begin
                if (word != TOMB && word != EMPTY && word_id == id_q) begin
                    hit_side_d = side_q;
                    hit_addr_d = index_q;
                    old_qty_d  = word_qty;
                    if (reduce_q == '0 || reduce_q >= word_qty) begin
                        wdata_d  = TOMB;
                        status_d = ST_DELETED;
                    end else begin
                        wdata_d  = {word_head, word_qty - reduce_q};
                        status_d = ST_REDUCED;
                    end
                    buy_we_d  = ~side_q;
                    sell_we_d = side_q;
                    state_d   = S_WRITE;
                end else if (word != EMPTY && index_q != LAST_IDX) begin
                    index_d = index_q + 1'b1;
                    state_d = S_SCAN;
                end else if (side_sel_q == SIDE_SEL_BOTH && !side_q) begin
                    side_d  = 1'b1;
                    index_d = '0;
                    state_d = S_SCAN;
                end else begin
                    status_d = ST_NOT_FOUND;
                    state_d  = S_DONE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            side_sel_q <= '0;
            reduce_q   <= '0;
            index_q    <= '0;
            side_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            buy_we_q   <= 1'b0;
            sell_we_q  <= 1'b0;
            wdata_q    <= '0;
            status_q   <= ST_NOT_FOUND;
            hit_side_q <= 1'b0;
            hit_addr_q <= '0;
            old_qty_q  <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            side_sel_q <= side_sel_d;
            reduce_q   <= reduce_d;
            index_q    <= index_d;
            side_q     <= side_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            buy_we_q   <= buy_we_d;
            sell_we_q  <= sell_we_d;
            wdata_q    <= wdata_d;
            status_q   <= status_d;
            hit_side_q <= hit_side_d;
            hit_addr_q <= hit_addr_d;
            old_qty_q  <= old_qty_d;
        end
    end

    // Strobes are gated by rst so a reset landing in WRITE never reaches the RAM.
    assign buy_we     = buy_we_q & ~rst;
    assign sell_we    = sell_we_q & ~rst;
    assign buy_wdata  = wdata_q;
    assign sell_wdata = wdata_q;
    assign buy_addr   = index_q;
    assign sell_addr  = index_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign hit_side   = hit_side_q;
    assign hit_addr   = hit_addr_q;
    assign old_qty    = old_qty_q;

endmodule

// File: tb/tb_order_cancel_engine.sv
// tb/tb_order_cancel_engine.sv - directed bench with a behavioural book-scan model for order_cancel_engine
module tb_order_cancel_engine;

    localparam int DEPTH = 8;
    localparam int W     = 48;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   id_i;
    logic [1:0]    side_sel;
    logic [15:0]   reduce_qty;
    logic [AW-1:0] buy_addr, sell_addr, hit_addr;
    logic [W-1:0]  buy_rdata, sell_rdata, buy_wdata, sell_wdata;
    logic          buy_we, sell_we, busy, done, hit_side;
    logic [1:0]    status;
    logic [15:0]   old_qty;

    always #5 clk = ~clk;

    order_cancel_engine #(.ID_W(16), .PRICE_W(16), .QTY_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .id(id_i), .side_sel(side_sel),
        .reduce_qty(reduce_qty),
        .buy_addr(buy_addr), .buy_rdata(buy_rdata), .buy_wdata(buy_wdata), .buy_we(buy_we),
        .sell_addr(sell_addr), .sell_rdata(sell_rdata), .sell_wdata(sell_wdata), .sell_we(sell_we),
        .busy(busy), .done(done), .status(status), .hit_side(hit_side),
        .hit_addr(hit_addr), .old_qty(old_qty)
    );

    // Book RAMs with 1-cycle read latency; the bench loads them through the same process.
    logic [W-1:0]  buy_mem [DEPTH];
    logic [W-1:0]  sell_mem[DEPTH];
    logic          ld_en = 1'b0, ld_clr = 1'b0, ld_side = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                buy_mem[i]  <= '0;
                sell_mem[i] <= '0;
            end
        end else if (ld_en) begin
            if (ld_side) sell_mem[ld_addr] <= ld_data;
            else         buy_mem[ld_addr]  <= ld_data;
        end
        if (buy_we)  buy_mem[buy_addr]   <= buy_wdata;
        if (sell_we) sell_mem[sell_addr] <= sell_wdata;
        buy_rdata  <= buy_mem[buy_addr];
        sell_rdata <= sell_mem[sell_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome of the request being run
    int            exp_lat;
    logic [1:0]    exp_status;
    logic          exp_write, exp_side;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_old;
    logic [W-1:0]  exp_wdata;

    task automatic model(input logic [15:0] mid, input logic [1:0] ss, input logic [15:0] red);
        int   sides[$];
        int   e;
        logic found;
        logic [W-1:0] w;
        exp_write = 1'b0; exp_side = 1'b0; exp_addr = '0; exp_old = '0; exp_wdata = '0;
        if (mid == 16'h0 || mid == 16'hFFFF || ss == 2'b00) begin
            exp_status = 2'b11;
            exp_lat    = 1;
            return;
        end
        if (ss[0]) sides.push_back(0);
        if (ss[1]) sides.push_back(1);
        e = 0; found = 1'b0; w = '0;
        for (int k = 0; k < sides.size() && !found; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = (sides[k] == 1) ? sell_mem[i] : buy_mem[i];
                e++;
                if (w == {W{1'b1}}) continue;
                if (w == '0) break;
                if (w[47:32] == mid) begin
                    found    = 1'b1;
                    exp_side = (sides[k] == 1);
                    exp_addr = i[AW-1:0];
                    exp_old  = w[15:0];
                    break;
                end
            end
        end
        if (found) begin
            exp_write = 1'b1;
            if (red == 0 || red >= exp_old) begin
                exp_wdata  = {W{1'b1}};
                exp_status = 2'b00;
            end else begin
                exp_wdata  = {w[47:16], exp_old - red};
                exp_status = 2'b01;
            end
            exp_lat = 2 * e + 2;
        end else begin
            exp_status = 2'b10;
            exp_lat    = 2 * e + 1;
        end
    endtask

    // Compare process: per-cycle check of every request the driver issues
    int          req_issued = 0;
    int          req_done   = 0;
    logic        mon_busy   = 1'b0;
    int          cyc        = 0;
    int          max_addr   = 0;
    logic        saw_last   = 1'b0;
    logic        wrapped    = 1'b0;

    always @(negedge clk) begin
        if (req_issued != req_done) begin
            logic wcyc;
            if (!mon_busy) begin
                mon_busy = 1'b1;
                cyc = 0; max_addr = 0; saw_last = 1'b0; wrapped = 1'b0;
            end else begin
                cyc++;
            end
            if (cyc >= 1) begin
                if (int'(buy_addr) > max_addr) max_addr = int'(buy_addr);
                if (saw_last && buy_addr == '0) wrapped = 1'b1;
                if (buy_addr == AW'(DEPTH - 1)) saw_last = 1'b1;
            end
            wcyc = exp_write && (cyc == exp_lat - 1);
            chk("busy", busy, cyc >= 1);
            chk("done", done, cyc == exp_lat);
            chk("buy_we", buy_we, wcyc && !exp_side);
            chk("sell_we", sell_we, wcyc && exp_side);
            if (wcyc) begin
                chk("we_addr", exp_side ? sell_addr : buy_addr, exp_addr);
                chk("wdata", exp_side ? sell_wdata : buy_wdata, exp_wdata);
            end
            if (cyc == exp_lat) begin
                chk("status", status, exp_status);
                if (exp_write) begin
                    chk("hit_side", hit_side, exp_side);
                    chk("hit_addr", hit_addr, exp_addr);
                    chk("old_qty", old_qty, exp_old);
                end
                mon_busy = 1'b0;
                req_done++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ld(input logic s, input int a, input logic [W-1:0] d);
        ld_en = 1'b1; ld_side = s; ld_addr = a[AW-1:0]; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic clr();
        ld_clr = 1'b1;
        step();
        ld_clr = 1'b0;
    endtask

    function automatic logic [W-1:0] mk(input int i, input int p, input int q);
        return {i[15:0], p[15:0], q[15:0]};
    endfunction

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic do_req(input logic [15:0] rid, input logic [1:0] ss, input logic [15:0] red,
                          input logic poke);
        model(rid, ss, red);
        start = 1'b1; id_i = rid; side_sel = ss; reduce_qty = red;
        req_issued++;
        step();
        start = 1'b0;
        for (int t = 0; t < 300 && req_done != req_issued; t++) begin
            step();
            if (poke && t == 1) begin
                start = 1'b1; id_i = 16'h0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (req_done != req_issued) begin
            errors++;
            checks++;
            $display("FAIL timeout: done not seen for id %0h", rid);
            finish_now();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; id_i = '0; side_sel = '0; reduce_qty = '0;
        clr();
        repeat (2) step();
        rst = 1'b0;

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_we", {buy_we, sell_we}, 2'b00);
        chk("rst_status", status, 2'b10);
        chk("rst_hit", {hit_side, hit_addr, old_qty}, '0);

        // Full cancel at address 0
        ld(0, 0, mk(5, 100, 10));
        do_req(16'd5, 2'b01, 16'd0, 1'b0);
        chk("t1_lat", exp_lat, 4);
        chk("t1_mem", buy_mem[0], 48'hFFFF_FFFF_FFFF);

        // Miss across both sides, buy ends at an empty slot, sell empty
        clr();
        ld(0, 0, mk(1, 10, 1)); ld(0, 1, mk(2, 10, 1)); ld(0, 2, mk(3, 10, 1));
        do_req(16'd9, 2'b11, 16'd0, 1'b0);
        chk("t2_lat", exp_lat, 11);
        chk("t2_status", status, 2'b10);

        // Tombstone skipped, partial reduce
        clr();
        ld(0, 0, {W{1'b1}}); ld(0, 1, mk(7, 100, 10));
        do_req(16'd7, 2'b01, 16'd4, 1'b0);
        chk("t3_lat", exp_lat, 6);
        chk("t3_mem", buy_mem[1], 48'h0007_0064_0006);
        chk("t3_old", old_qty, 16'd10);

        // Over-reduce deletes; start during busy is ignored
        clr();
        ld(0, 0, mk(7, 100, 10));
        do_req(16'd7, 2'b01, 16'd12, 1'b1);
        chk("t4_mem", buy_mem[0], 48'hFFFF_FFFF_FFFF);
        chk("t4_status", status, 2'b00);

        // Full side, no match: index stops at the last entry
        clr();
        for (int i = 0; i < DEPTH; i++) ld(0, i, mk(11 + i, 50, 5));
        do_req(16'd99, 2'b01, 16'd0, 1'b0);
        chk("t5_lat", exp_lat, 17);
        chk("t5_maxaddr", max_addr, 7);
        chk("t5_wrap", wrapped, 1'b0);

        // Bad requests
        do_req(16'h0000, 2'b01, 16'd0, 1'b0);
        chk("t6_lat", exp_lat, 1);
        chk("t6_status", status, 2'b11);
        do_req(16'hFFFF, 2'b01, 16'd0, 1'b0);
        do_req(16'd11, 2'b00, 16'd0, 1'b0);
        chk("t6_mem", buy_mem[0], mk(11, 50, 5));

        // Sell only, hit past a tombstone
        clr();
        ld(1, 0, mk(21, 200, 4)); ld(1, 1, {W{1'b1}}); ld(1, 2, mk(20, 200, 9));
        ld(0, 0, mk(20, 1, 1));
        do_req(16'd20, 2'b10, 16'd0, 1'b0);
        chk("t7_lat", exp_lat, 8);
        chk("t7_buy_untouched", buy_mem[0], mk(20, 1, 1));

        // Both sides, found on sell after buy end
        clr();
        ld(0, 0, mk(1, 10, 1)); ld(1, 0, mk(30, 90, 5));
        do_req(16'd30, 2'b11, 16'd3, 1'b0);
        chk("t8_mem", sell_mem[0], mk(30, 90, 2));
        chk("t8_side", hit_side, 1'b1);

        // Only the first match is modified
        clr();
        ld(0, 0, mk(4, 50, 3)); ld(0, 1, mk(4, 60, 8));
        do_req(16'd4, 2'b01, 16'd0, 1'b0);
        chk("t9_first", buy_mem[0], 48'hFFFF_FFFF_FFFF);
        chk("t9_second", buy_mem[1], mk(4, 60, 8));

        // Buy-only request must not look at sell
        clr();
        ld(1, 0, mk(40, 1, 1));
        do_req(16'd40, 2'b01, 16'd0, 1'b0);
        chk("t10_status", status, 2'b10);
        chk("t10_mem", sell_mem[0], mk(40, 1, 1));

        // Reset during WRITE suppresses the strobe and returns to idle
        clr();
        ld(0, 0, mk(5, 100, 10));
        start = 1'b1; id_i = 16'd5; side_sel = 2'b01; reduce_qty = 16'd0;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t11_we_gated", buy_we, 1'b0);
        step();
        rst = 1'b0;
        chk("t11_busy", busy, 1'b0);
        chk("t11_done", done, 1'b0);
        chk("t11_status", status, 2'b10);
        chk("t11_mem", buy_mem[0], mk(5, 100, 10));

        // Normal operation after that reset
        do_req(16'd5, 2'b01, 16'd3, 1'b0);
        chk("t12_mem", buy_mem[0], mk(5, 100, 7));

        repeat (2) step();
        finish_now();
    end

endmodule
